// File: rtl/debug_pkg.sv
// Shared types and ASCII constants for the debug frame streamer.
package debug_pkg;

    // Frame sequencer states: hex digits, channel separator, then CR/LF trailer.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HEX  = 3'd1,
        SEP  = 3'd2,
        CR   = 3'd3,
        LF   = 3'd4
    } state_e;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] HEX_BASE  = 8'h30;  // '0'
    localparam logic [7:0] HEX_ALPHA = 8'h41;  // 'A'

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex character.
module nibble_to_ascii
    import debug_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    // 0-9 from '0', 10-15 from 'A'.
    always_comb begin
        if (nib_i < 4'd10) ascii_o = HEX_BASE + {4'h0, nib_i};
        else               ascii_o = HEX_ALPHA + {4'h0, nib_i} - 8'd10;
    end

endmodule

// File: rtl/debug_frame_streamer.sv
// Streams a snapshot of debug channel words as an ASCII hex line toward a UART.
module debug_frame_streamer
    import debug_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned BYTES_PER_CH  = 4,
    parameter int unsigned PERIOD_CYCLES = 12000000,
    parameter logic [7:0]  SEP_CHAR      = 8'h20
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_CH*BYTES_PER_CH*8-1:0]   ch_data,
    input  logic [NUM_CH-1:0]                  ch_enable,
    input  logic                               mode,
    input  logic                               start,
    output logic [7:0]                         tx_data,
    output logic                               tx_valid,
    input  logic                               tx_ready,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               dropped
);

    localparam int unsigned NIB   = 2 * BYTES_PER_CH;
    localparam int unsigned NIB_W = $clog2(NIB);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES);
    localparam int unsigned DW    = NUM_CH * BYTES_PER_CH * 8;

    state_e             state_q, state_d;
    logic [DW-1:0]      data_q, data_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [NIB_W-1:0]   nib_q, nib_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;

    logic               tick, req, active, xfer;
    logic [CH_W-1:0]    first_ch, next_ch;
    logic               has_next;
    logic [3:0]         nib_sel;
    logic [7:0]         hex_char;

    assign active = (state_q != IDLE);
    assign xfer   = active && tx_ready;

    // Period counter runs only in periodic mode and wraps on the tick.
    always_comb begin
        tick  = mode && (per_q == CNT_W'(PERIOD_CYCLES - 1));
        per_d = (!mode || tick) ? '0 : per_q + CNT_W'(1);
    end

    assign req = mode ? tick : start;

    // Lowest enabled channel of the live mask, and next enabled channel after ch_q in the snapshot.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ch_enable[c]) first_ch = CH_W'(c);
            if (mask_q[c] && (CH_W'(c) > ch_q)) begin
                next_ch  = CH_W'(c);
                has_next = 1'b1;
            end
        end
    end

    // Select the current nibble, most significant nibble of the channel first.
    always_comb begin
        nib_sel = 4'h0;
        for (int c = 0; c < NUM_CH; c++)
            for (int n = 0; n < NIB; n++)
                if (ch_q == CH_W'(c) && nib_q == NIB_W'(n))
                    nib_sel = data_q[(c*NIB + NIB - 1 - n)*4 +: 4];
    end

    nibble_to_ascii u_hex (
        .nib_i   (nib_sel),
        .ascii_o (hex_char)
    );

    // Next-state logic: snapshot on request in IDLE, advance only on a transfer.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        nib_d   = nib_q;
        unique case (state_q)
            IDLE: if (req) begin
                data_d  = ch_data;
                mask_d  = ch_enable;
                ch_d    = first_ch;
                nib_d   = '0;
                state_d = (ch_enable == '0) ? CR : HEX;
            end
            HEX: if (tx_ready) begin
                if (nib_q == NIB_W'(NIB - 1)) begin
                    nib_d = '0;
                    if (has_next) begin
                        ch_d    = next_ch;
                        state_d = SEP;
                    end else begin
                        state_d = CR;
                    end
                end else begin
                    nib_d = nib_q + NIB_W'(1);
                end
            end
            SEP: if (tx_ready) state_d = HEX;
            CR:  if (tx_ready) state_d = LF;
            LF:  if (tx_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte presented to the sink, held stable by the registered state while stalled.
    always_comb begin
        tx_data = 8'h00;
        unique case (state_q)
            HEX:     tx_data = hex_char;
            SEP:     tx_data = SEP_CHAR;
            CR:      tx_data = ASCII_CR;
            LF:      tx_data = ASCII_LF;
            default: tx_data = 8'h00;
        endcase
    end

    // Completion after LF is taken; requests seen while active (including the LF cycle) are lost.
    always_comb begin
        done_d = xfer && (state_q == LF);
        drop_d = req && active;
    end

    assign tx_valid   = active;
    assign busy       = active;
    assign frame_done = done_q;
    assign dropped    = drop_q;

    // State and snapshot registers, cleared asynchronously so reset aborts a frame at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            ch_q    <= '0;
            nib_q   <= '0;
            per_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            nib_q   <= nib_d;
            per_q   <= per_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_debug_frame_streamer.sv
// Self-checking bench: table vectors, corner sequences, randomized frames against a line model.
module tb_debug_frame_streamer;

    localparam int NCH = 2;
    localparam int BPC = 2;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
        int          stall_idx;
        int          stall_len;
        int          dup_at;
        int          nexp;
        logic [87:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ch_data;
    logic [1:0]  ch_enable;
    logic        mode, start, tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, frame_done, dropped;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    debug_frame_streamer #(
        .NUM_CH(NCH), .BYTES_PER_CH(BPC), .PERIOD_CYCLES(64), .SEP_CHAR(8'h20)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ch_data(ch_data), .ch_enable(ch_enable),
        .mode(mode), .start(start), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done), .dropped(dropped)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference line: hex of each enabled channel, space-separated, then CR LF.
    function automatic bq_t build_frame(input logic [31:0] d, input logic [1:0] m);
        bq_t q;
        bit first = 1'b1;
        q = {};
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) begin
                if (!first) q.push_back(8'h20);
                first = 1'b0;
                for (int k = 2*BPC - 1; k >= 0; k--) begin
                    int v;
                    v = int'((d >> (c*BPC*8 + k*4)) & 32'hF);
                    q.push_back(v < 10 ? 8'(48 + v) : 8'(55 + v));
                end
            end
        end
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic cmp_frame(input string name, input bq_t got, input bq_t exp);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk({name, "_byte"}, got[i], exp[i]);
    endtask

    // One triggered frame with optional stall and an extra start while busy.
    task automatic run_frame(input string name, input logic [31:0] d, input logic [1:0] m,
                             input int stall_idx, input int stall_len, input int dup_at,
                             input bq_t exp);
        bq_t got;
        int  drops = 0, busy_n = 0, nb = 0, stall_left = 0, extra = 0;
        bit  done = 1'b0;
        got = {};
        @(negedge clk);
        ch_data = d; ch_enable = m; start = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ch_data = $urandom; ch_enable = 2'($urandom);
        chk({name, "_latency"}, tx_valid, 1'b1);
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (dropped) drops++;
            start = (!frame_done && cyc == dup_at);
            if (frame_done) begin
                done = 1'b1;
            end else begin
                if (busy) busy_n++;
                if (nb == stall_idx && stall_left < stall_len) begin
                    tx_ready = 1'b0;
                    stall_left++;
                    chk({name, "_stall_valid"}, tx_valid, 1'b1);
                    if (nb < exp.size()) chk({name, "_stall_data"}, tx_data, exp[nb]);
                end else begin
                    tx_ready = 1'b1;
                end
                if (tx_valid && tx_ready) begin
                    got.push_back(tx_data);
                    nb++;
                end
                @(negedge clk);
            end
        end
        chk({name, "_completed"}, done, 1'b1);
        cmp_frame(name, got, exp);
        chk({name, "_busy_cycles"}, busy_n, exp.size() + stall_len);
        @(negedge clk);
        if (dropped) drops++;
        chk({name, "_done_single"}, frame_done, 1'b0);
        chk({name, "_drops"}, drops, (dup_at >= 0) ? 1 : 0);
        for (int i = 0; i < 10; i++) begin
            if (tx_valid || busy) extra++;
            @(negedge clk);
        end
        chk({name, "_no_extra_frame"}, extra, 0);
    endtask

    vec_t vecs[7];
    bq_t  exp, cur;
    int   starts[$];
    bit   pb;

    initial begin
        vecs[0] = '{32'hABCD_0123, 2'b11, -1, 0, -1, 11,
                    {8'h30,8'h31,8'h32,8'h33,8'h20,8'h41,8'h42,8'h43,8'h44,8'h0D,8'h0A}};
        vecs[1] = '{32'hABCD_0123, 2'b10, -1, 0, -1, 6,
                    {8'h41,8'h42,8'h43,8'h44,8'h0D,8'h0A}};
        vecs[2] = '{32'hABCD_0123, 2'b00, -1, 0, -1, 2, {8'h0D,8'h0A}};
        vecs[3] = '{32'hABCD_0123, 2'b11, 2, 5, -1, 11,
                    {8'h30,8'h31,8'h32,8'h33,8'h20,8'h41,8'h42,8'h43,8'h44,8'h0D,8'h0A}};
        vecs[4] = '{32'hABCD_0123, 2'b11, -1, 0, 3, 11,
                    {8'h30,8'h31,8'h32,8'h33,8'h20,8'h41,8'h42,8'h43,8'h44,8'h0D,8'h0A}};
        vecs[5] = '{32'h0000_0000, 2'b00, -1, 0, 1, 2, {8'h0D,8'h0A}};
        vecs[6] = '{32'h89EF_4567, 2'b01, -1, 0, -1, 6,
                    {8'h34,8'h35,8'h36,8'h37,8'h0D,8'h0A}};

        reset_n = 1'b0; ch_data = '0; ch_enable = '0; mode = 1'b0; start = 1'b0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_tx_data", tx_data, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_frame_done", frame_done, 1'b0);
        chk("reset_dropped", dropped, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors with literal expected bytes.
        for (int v = 0; v < 7; v++) begin
            bq_t e;
            e = {};
            for (int i = 0; i < vecs[v].nexp; i++)
                e.push_back(vecs[v].exp[(vecs[v].nexp - 1 - i)*8 +: 8]);
            run_frame($sformatf("vec%0d", v), vecs[v].d, vecs[v].m,
                      vecs[v].stall_idx, vecs[v].stall_len, vecs[v].dup_at, e);
        end

        // Randomized frames against the line model.
        for (int r = 0; r < 20; r++) begin
            logic [31:0] d;
            logic [1:0]  m;
            int          sl, si, du;
            d  = $urandom;
            m  = 2'($urandom);
            exp = build_frame(d, m);
            sl = int'($urandom_range(0, 3));
            si = int'($urandom_range(0, exp.size() - 1));
            du = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, exp.size() - 1)) : -1;
            run_frame($sformatf("rand%0d", r), d, m, si, sl, du, exp);
        end

        // Periodic mode: frames every 64 cycles, then reset in the middle of one.
        @(negedge clk);
        ch_data = 32'h5A5A_C3E1; ch_enable = 2'b11; tx_ready = 1'b1; mode = 1'b1;
        exp = build_frame(ch_data, ch_enable);
        starts = {}; cur = {}; pb = 1'b0;
        for (int cyc = 0; cyc < 400 && !(starts.size() == 4 && cur.size() == 3); cyc++) begin
            @(negedge clk);
            if (busy && !pb) starts.push_back(cyc);
            pb = busy;
            if (tx_valid) cur.push_back(tx_data);
            if (frame_done) begin
                cmp_frame("periodic_frame", cur, exp);
                cur = {};
            end
        end
        chk("periodic_start_count", starts.size(), 4);
        for (int i = 1; i < starts.size(); i++)
            chk("periodic_interval", starts[i] - starts[i-1], 64);

        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_tx_valid", tx_valid, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_tx_data", tx_data, 8'h00);
        reset_n = 1'b1;
        cur = {}; starts = {}; pb = 1'b0;
        begin
            bit done = 1'b0;
            for (int cyc = 0; cyc < 200 && !done; cyc++) begin
                @(negedge clk);
                if (busy && !pb) starts.push_back(cyc);
                pb = busy;
                if (tx_valid) cur.push_back(tx_data);
                if (frame_done) done = 1'b1;
            end
            chk("postreset_completed", done, 1'b1);
        end
        chk("postreset_start_cycle", (starts.size() > 0) ? starts[0] : -1, 63);
        cmp_frame("postreset_frame", cur, exp);

        mode = 1'b0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debug_frame_streamer.md
DEBUG_FRAME_STREAMER -- requirements
Module: debug_frame_streamer

Interface
REQ-001 Parameter NUM_CH, default 4: number of debug channels, legal range 1..8.
REQ-002 Parameter BYTES_PER_CH, default 4: bytes per channel, legal range 1..16.
REQ-003 Parameter PERIOD_CYCLES, default 12000000: frame interval in periodic mode, minimum 64.
REQ-004 Parameter SEP_CHAR, default 8'h20: separator byte placed between channels.
REQ-005 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port ch_data, input, NUM_CH*BYTES_PER_CH*8: channel words; channel 0 occupies the LSBs.
REQ-008 Port ch_enable, input, NUM_CH: per-channel include mask.
REQ-009 Port mode, input, 1: 0 = trigger mode, 1 = periodic mode.
REQ-010 Port start, input, 1: one-cycle request pulse, honoured in trigger mode only.
REQ-011 Port tx_data, output, 8: ASCII byte sent toward the UART transmitter.
REQ-012 Port tx_valid, output, 1: tx_data is valid.
REQ-013 Port tx_ready, input, 1: the sink accepts the byte.
REQ-014 Port busy, output, 1: high while a frame is in progress.
REQ-015 Port frame_done, output, 1: one-cycle pulse when a frame completes.
REQ-016 Port dropped, output, 1: one-cycle pulse when a request is lost.

Function
REQ-017 A request is a start pulse when mode=0, or a period tick when mode=1.
REQ-018 The period counter shall run only while mode=1 and shall be held at 0 while mode=0.
REQ-019 The period tick shall fire when the counter reaches PERIOD_CYCLES-1; the counter then wraps to 0.
REQ-020 A request in IDLE shall snapshot ch_data and ch_enable into internal registers; later input changes shall not alter the frame.
REQ-021 Frame content: for each enabled channel, in ascending channel index, emit 2*BYTES_PER_CH hex characters, most significant nibble first.
REQ-022 Hex characters shall be uppercase ASCII: 0-9 map to 8'h30-8'h39, A-F map to 8'h41-8'h46.
REQ-023 SEP_CHAR shall be emitted between consecutive enabled channels only, never after the last one.
REQ-024 Every frame shall end with 8'h0D followed by 8'h0A.
REQ-025 If no channel is enabled in the snapshot, the frame shall be 8'h0D, 8'h0A only.
REQ-026 The state machine shall use states IDLE, HEX, SEP, CR and LF.
REQ-027 Transitions: IDLE->HEX on a request, or IDLE->CR if the mask is zero.
REQ-028 Transitions: HEX->SEP after the last nibble if another enabled channel remains, otherwise HEX->CR.
REQ-029 Transitions: SEP->HEX and CR->LF each on byte acceptance; LF->IDLE on acceptance of 8'h0A.
REQ-030 A byte transfers on a clock edge where tx_valid and tx_ready are both high; the state or nibble index advances only on a transfer.
REQ-031 While tx_valid is high and tx_ready is low, tx_data shall be held stable and tx_valid shall stay high.
REQ-032 Latency: tx_valid shall rise in the cycle after the request is sampled.
REQ-033 After a byte is accepted, the next byte shall be presented in the following cycle, giving back-to-back transfers at full rate.
REQ-034 busy shall be high from the cycle after the request until the cycle after 8'h0A is accepted.
REQ-035 frame_done shall pulse in the cycle after 8'h0A is accepted.
REQ-036 A request arriving while busy shall be ignored; dropped shall pulse for one cycle; the current frame continues unaffected.
REQ-037 A request coinciding with acceptance of 8'h0A shall be dropped, because the block is still busy in that cycle.
REQ-038 A change of mode mid-frame shall not abort the frame in progress.

Reset
REQ-039 When reset_n is low: tx_valid=0, tx_data=8'h00, busy=0, frame_done=0, dropped=0, state=IDLE, period counter=0, snapshot registers=0.
REQ-040 Asserting reset mid-frame shall abort the frame immediately; no partial byte transfer shall complete after deassertion.

Structure
REQ-041 Package debug_pkg shall hold the state enum and the ASCII constants CR, LF and HEX_BASE values.
REQ-042 Sub-module nibble_to_ascii shall be purely combinational, mapping 4 bits to 8 bits.

Verification
REQ-043 NUM_CH=2, BYTES_PER_CH=2, ch_data=32'hABCD_0123, mask 2'b11, tx_ready=1, one start pulse -> bytes 30 31 32 33 20 41 42 43 44 0D 0A, then frame_done.
REQ-044 Same data, mask 2'b10 -> bytes 41 42 43 44 0D 0A, with no separator.
REQ-045 Mask 2'b00 -> bytes 0D 0A only; busy lasts 2 transfers.
REQ-046 tx_ready held low for 5 cycles on the 3rd byte -> tx_data stays 32 throughout the stall; the frame resumes intact.
REQ-047 Second start pulse mid-frame -> dropped pulses once; exactly one frame is emitted.
REQ-048 mode=1, PERIOD_CYCLES=64, tx_ready=1 -> a frame starts every 64 cycles; reset_n pulled low mid-frame -> tx_valid=0 in the next cycle, the state returns to IDLE, and the next frame is complete.
